// File: rtl/soc_periph_req_scheduler.sv
// Round-robin scheduler that shares one SoC peripheral port among NrReq masters,
// decodes the granted address against the SoC map and times out missing responses.
module soc_periph_req_scheduler #(
    parameter int unsigned NrReq         = 4,
    parameter int unsigned AddrWidth     = 64,
    parameter int unsigned DataWidth     = 64,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NrReq-1:0]           req_valid_i,
    output logic [NrReq-1:0]           req_ready_o,
    input  logic [NrReq*AddrWidth-1:0] req_addr_i,
    input  logic [NrReq-1:0]           req_we_i,
    input  logic [NrReq*DataWidth-1:0] req_wdata_i,
    output logic [NrReq-1:0]           rsp_valid_o,
    output logic [DataWidth-1:0]       rsp_rdata_o,
    output logic                       rsp_err_o,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [AddrWidth-1:0]       out_addr_o,
    output logic                       out_we_o,
    output logic [DataWidth-1:0]       out_wdata_o,
    output logic [3:0]                 out_slave_o,
    input  logic                       resp_valid_i,
    input  logic [DataWidth-1:0]       resp_rdata_i,
    input  logic                       resp_err_i,
    output logic                       busy_o,
    output logic [15:0]                timeout_cnt_o
);

    localparam int unsigned PW    = (NrReq > 1) ? $clog2(NrReq) : 1;
    localparam int unsigned TW    = $clog2(TimeoutCycles) + 1;
    localparam int unsigned NrSlv = 13;

    // IDLE grant+decode | ISSUE drive downstream | WAIT_RESP timed wait | RESPOND one-cycle strobe | DRAIN swallow late response
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] ISSUE     = 3'd1;
    localparam logic [2:0] WAIT_RESP = 3'd2;
    localparam logic [2:0] RESPOND   = 3'd3;
    localparam logic [2:0] DRAIN     = 3'd4;

    localparam logic [63:0] SLV_BASE [NrSlv] = '{
        64'h0000_0000, 64'h0001_0000, 64'h0200_0000, 64'h0C00_0000, 64'h1000_0000,
        64'h1C00_0000, 64'h1A10_0000, 64'h1800_0000, 64'h2000_0000, 64'h3000_0000,
        64'h4000_0000, 64'h1040_0000, 64'h8000_0000};
    localparam logic [63:0] SLV_LEN [NrSlv] = '{
        64'h0000_1000, 64'h0001_0000, 64'h000C_0000, 64'h03FF_FFFF, 64'h0040_0000,
        64'h0008_0000, 64'h0012_3000, 64'h0000_1000, 64'h0080_0000, 64'h0001_0000,
        64'h0000_1000, 64'h0010_0000, 64'h2000_0000};

    logic [2:0]           state;
    logic [PW-1:0]        rr_ptr, gnt_q, gnt_idx;
    logic                 gnt_found;
    logic [AddrWidth-1:0] gnt_addr;
    logic [63:0]          gnt_addr64;
    logic                 dec_hit;
    logic [3:0]           dec_slave;
    logic [TW-1:0]        timer;
    logic                 drain_q;
    logic [DataWidth-1:0] rdata_q;
    logic                 err_q;
    logic [15:0]          tcnt_q;

    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int i = 0; i < int'(NrReq); i++) begin
            if (!gnt_found && req_valid_i[(int'(rr_ptr) + i) % int'(NrReq)]) begin
                gnt_found = 1'b1;
                gnt_idx   = PW'((int'(rr_ptr) + i) % int'(NrReq));
            end
        end
    end

    assign gnt_addr = req_addr_i[gnt_idx*AddrWidth +: AddrWidth];

    // Scan from the top so the lowest matching region index wins on overlap.
    always_comb begin
        gnt_addr64                = '0;
        gnt_addr64[AddrWidth-1:0] = gnt_addr;
        dec_hit                   = 1'b0;
        dec_slave                 = '0;
        for (int s = int'(NrSlv) - 1; s >= 0; s--) begin
            if (gnt_addr64 >= SLV_BASE[s] && gnt_addr64 < SLV_BASE[s] + SLV_LEN[s]) begin
                dec_hit   = 1'b1;
                dec_slave = 4'(s);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            gnt_q       <= '0;
            out_addr_o  <= '0;
            out_we_o    <= 1'b0;
            out_wdata_o <= '0;
            out_slave_o <= '0;
            timer       <= '0;
            drain_q     <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            tcnt_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_found) begin
                        gnt_q       <= gnt_idx;
                        out_addr_o  <= gnt_addr;
                        out_we_o    <= req_we_i[gnt_idx];
                        out_wdata_o <= req_wdata_i[gnt_idx*DataWidth +: DataWidth];
                        out_slave_o <= dec_slave;
                        if (dec_hit) begin
                            state <= ISSUE;
                        end else begin
                            rdata_q <= '0;
                            err_q   <= 1'b1;
                            state   <= RESPOND;
                        end
                    end
                end
                ISSUE: begin
                    if (out_ready_i) begin
                        timer <= '0;
                        state <= WAIT_RESP;
                    end
                end
                WAIT_RESP: begin
                    timer <= timer + 1'b1;
                    if (resp_valid_i) begin
                        rdata_q <= resp_rdata_i;
                        err_q   <= resp_err_i;
                        state   <= RESPOND;
                    end else if (timer == TW'(TimeoutCycles - 1)) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                        drain_q <= 1'b1;
                        if (tcnt_q != 16'hFFFF) tcnt_q <= tcnt_q + 16'd1;
                        state   <= RESPOND;
                    end
                end
                RESPOND: begin
                    rr_ptr <= (gnt_q == PW'(NrReq - 1)) ? '0 : gnt_q + 1'b1;
                    state  <= drain_q ? DRAIN : IDLE;
                end
                DRAIN: begin
                    if (resp_valid_i) begin
                        drain_q <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Reset is folded in so no accept leaks out while the block is held in reset.
    always_comb begin
        req_ready_o = '0;
        if (!rst_i && state == IDLE && gnt_found) req_ready_o[gnt_idx] = 1'b1;
    end

    always_comb begin
        rsp_valid_o = '0;
        if (state == RESPOND) rsp_valid_o[gnt_q] = 1'b1;
    end

    assign rsp_rdata_o   = (state == RESPOND) ? rdata_q : '0;
    assign rsp_err_o     = (state == RESPOND) && err_q;
    assign out_valid_o   = (state == ISSUE);
    assign busy_o        = (state != IDLE);
    assign timeout_cnt_o = tcnt_q;

endmodule
